// File: rtl/c3sram_burst_sequencer_if.sv
// Host-side interface of the C3SRAM burst sequencer.
// Carries the row request (valid/ready, direction, bank, start row, length-1),
// the sticky abort, the write-data beat (valid/ready) and the read-data return
// (1-cycle valid pulse, no backpressure) plus the end-of-burst done pulse.
//   slave  : sequencer side
//   master : host/loader side
interface c3sram_burst_sequencer_if #(
    parameter int NUM_COLS  = 32,
    parameter int NUM_ROWS  = 128,
    parameter int NUM_BANKS = 2,
    parameter int MAX_BURST = 16
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_write_i;
    logic [BANK_W-1:0]   req_bank_i;
    logic [ROW_W-1:0]    req_addr_i;
    logic [LEN_W-1:0]    req_len_i;
    logic                abort_i;
    logic [NUM_COLS-1:0] wr_data_i;
    logic                wr_data_valid_i;
    logic                wr_data_ready_o;
    logic [NUM_COLS-1:0] rd_data_o;
    logic                rd_valid_o;
    logic                done_o;

    modport slave (
        input  req_valid_i, req_write_i, req_bank_i, req_addr_i, req_len_i,
               abort_i, wr_data_i, wr_data_valid_i,
        output req_ready_o, wr_data_ready_o, rd_data_o, rd_valid_o, done_o
    );

    modport master (
        output req_valid_i, req_write_i, req_bank_i, req_addr_i, req_len_i,
               abort_i, wr_data_i, wr_data_valid_i,
        input  req_ready_o, wr_data_ready_o, rd_data_o, rd_valid_o, done_o
    );
endinterface

// File: rtl/c3sram_burst_sequencer.sv
// Multi-bank burst read/write sequencer for C3SRAM macros.
// Accepts a row request through the host interface, then for each row of the
// burst drives a PHASES-cycle precharge / wordline / write-to-bitline /
// sense-amp waveform on the array ports. Write bursts take one data beat per
// row; read bursts return the sensed row with a 1-cycle rd_valid pulse.
// Ports:
//   clk, nrst     : clock, asynchronous active-low reset
//   host          : request / abort / write beat / read return (slave modport)
//   bank_sel_o    : one-hot active bank during row access
//   nprecharge_o  : precharge release (active high)
//   w2b_o         : write-to-bitline enable
//   saen_o        : sense-amp enable
//   wl_o          : one-hot wordline
//   wdata_o       : latched write data driven to the array
//   sa_data_i     : sense-amp outputs
module c3sram_burst_sequencer #(
    parameter int NUM_ROWS  = 128,
    parameter int NUM_COLS  = 32,
    parameter int NUM_BANKS = 2,
    parameter int PHASES    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    c3sram_burst_sequencer_if.slave host,
    output logic [NUM_BANKS-1:0]    bank_sel_o,
    output logic                    nprecharge_o,
    output logic                    w2b_o,
    output logic                    saen_o,
    output logic [NUM_ROWS-1:0]     wl_o,
    output logic [NUM_COLS-1:0]     wdata_o,
    input  logic [NUM_COLS-1:0]     sa_data_i
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int PH_W   = $clog2(PHASES);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]  PH_SENSE = PH_W'(PHASES - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        WR_PHASE,
        RD_PHASE
    } state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic                abort_q, abort_d;
    logic [NUM_COLS-1:0] wdata_q, wdata_d;
    logic [NUM_COLS-1:0] rd_data_q, rd_data_d;

    logic in_phase;
    logic last_ph;
    logic abort_seen;
    logic wl_on;
    logic req_ready;
    logic wr_ready;
    logic done;

    assign in_phase   = (state_q == WR_PHASE) || (state_q == RD_PHASE);
    assign last_ph    = (ph_q == PH_LAST);
    // A live abort counts in the same cycle it is raised, not only once latched.
    assign abort_seen = abort_q | host.abort_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            row_q     <= '0;
            bank_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            abort_q   <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            row_q     <= row_d;
            bank_q    <= bank_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            abort_q   <= abort_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        row_d     = row_q;
        bank_d    = bank_q;
        len_d     = len_q;
        beat_d    = beat_q;
        abort_d   = abort_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                abort_d   = 1'b0;
                if (host.req_valid_i) begin
                    bank_d  = host.req_bank_i;
                    row_d   = host.req_addr_i;
                    len_d   = host.req_len_i;
                    beat_d  = '0;
                    ph_d    = '0;
                    state_d = host.req_write_i ? WR_WAIT : RD_PHASE;
                end
            end
            WR_WAIT: begin
                wr_ready = 1'b1;
                abort_d  = abort_seen;
                // Abort beats a simultaneous data beat: no array activity follows.
                if (abort_seen) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (host.wr_data_valid_i) begin
                    wdata_d = host.wr_data_i;
                    ph_d    = '0;
                    state_d = WR_PHASE;
                end
            end
            WR_PHASE, RD_PHASE: begin
                abort_d = abort_seen;
                if ((state_q == RD_PHASE) && (ph_q == PH_SENSE)) begin
                    rd_data_d = sa_data_i;
                end
                if (last_ph) begin
                    ph_d = '0;
                    if ((beat_q == len_q) || abort_seen) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = (state_q == WR_PHASE) ? WR_WAIT : RD_PHASE;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array controls decode straight from state/phase so reset clears them at once.
    assign wl_on        = in_phase && (ph_q != '0) && !last_ph;
    assign wl_o         = wl_on ? (NUM_ROWS'(1) << row_q) : '0;
    assign nprecharge_o = (state_q == WR_PHASE) || ((state_q == RD_PHASE) && !last_ph);
    assign w2b_o        = (state_q == WR_PHASE);
    assign saen_o       = (state_q == RD_PHASE) && (ph_q == PH_SENSE);
    assign wdata_o      = wdata_q;

    // Out-of-range bank codes match no bit, so no bank is selected.
    always_comb begin
        bank_sel_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_sel_o[b] = in_phase && (bank_q == BANK_W'(b));
        end
    end

    assign host.req_ready_o     = req_ready;
    assign host.wr_data_ready_o = wr_ready;
    assign host.rd_data_o       = rd_data_q;
    assign host.rd_valid_o      = (state_q == RD_PHASE) && last_ph;
    assign host.done_o          = done;
endmodule

// File: tb/tb_c3sram_burst_sequencer.sv
// Bench for c3sram_burst_sequencer: a reset/read/abort vector table, directed
// multi-cycle sequences, randomized traffic against a row-waveform reference
// model, and a PHASES=6 instance.
module tb_c3sram_burst_sequencer;
    localparam int NUM_ROWS  = 128;
    localparam int NUM_COLS  = 32;
    localparam int NUM_BANKS = 2;
    localparam int PHASES    = 4;
    localparam int MAX_BURST = 16;
    localparam int BANK_W    = 1;
    localparam int ROW_W     = 7;
    localparam int LEN_W     = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    c3sram_burst_sequencer_if #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS),
        .NUM_BANKS(NUM_BANKS), .MAX_BURST(MAX_BURST)) hif ();
    logic [NUM_BANKS-1:0] bank_sel;
    logic                 npre, w2b, saen;
    logic [NUM_ROWS-1:0]  wl;
    logic [NUM_COLS-1:0]  wdata, sa_data;

    c3sram_burst_sequencer #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .NUM_BANKS(NUM_BANKS),
        .PHASES(PHASES), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .nrst(nrst), .host(hif), .bank_sel_o(bank_sel), .nprecharge_o(npre),
        .w2b_o(w2b), .saen_o(saen), .wl_o(wl), .wdata_o(wdata), .sa_data_i(sa_data));

    c3sram_burst_sequencer_if #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS),
        .NUM_BANKS(NUM_BANKS), .MAX_BURST(MAX_BURST)) hif6 ();
    logic [NUM_BANKS-1:0] bank_sel6;
    logic                 npre6, w2b6, saen6;
    logic [NUM_ROWS-1:0]  wl6;
    logic [NUM_COLS-1:0]  wdata6, sa6;

    c3sram_burst_sequencer #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .NUM_BANKS(NUM_BANKS),
        .PHASES(6), .MAX_BURST(MAX_BURST)) dut6 (
        .clk(clk), .nrst(nrst), .host(hif6), .bank_sel_o(bank_sel6), .nprecharge_o(npre6),
        .w2b_o(w2b6), .saen_o(saen6), .wl_o(wl6), .wdata_o(wdata6), .sa_data_i(sa6));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] onehot(input int r);
        return (r < 0) ? 128'd0 : (128'd1 << r);
    endfunction

    function automatic logic [127:0] bank_hot(input int b);
        return (b < NUM_BANKS) ? (128'd1 << b) : 128'd0;
    endfunction

    function automatic int hot_index(input logic [NUM_ROWS-1:0] v);
        for (int i = 0; i < NUM_ROWS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- reference model: list of expected row cycles ----------------
    typedef struct {
        bit npre, w2b, saen, rdv, done;
        int row, bank;
        logic [31:0] wd;
    } cyc_t;

    cyc_t        exp_q[$];
    int          rows_left = 0;
    int          m_row = 0;
    int          m_bank = 0;
    logic [31:0] sa_prev = '0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rdv_cyc[$];
    int          wl_log[$];
    logic [31:0] wd_log[$];
    bit          prev_wl_on = 0;

    // Expand one row access into its PHASES-cycle waveform.
    function automatic void push_row(input bit wr, input int row, input int bank,
                                     input bit final_row, input logic [31:0] wd);
        for (int p = 0; p < PHASES; p++) begin
            cyc_t c;
            c.w2b  = wr;
            c.npre = wr ? 1'b1 : (p != PHASES - 1);
            c.saen = !wr && (p == PHASES - 2);
            c.rdv  = !wr && (p == PHASES - 1);
            c.done = final_row && (p == PHASES - 1);
            c.row  = (p >= 1 && p <= PHASES - 2) ? row : -1;
            c.bank = bank;
            c.wd   = wd;
            exp_q.push_back(c);
        end
    endfunction

    task automatic model_check();
        cyc_t c;
        bit   busy;
        busy = (exp_q.size() > 0);
        if (busy) c = exp_q[0];
        else begin
            c = '{npre: 0, w2b: 0, saen: 0, rdv: 0, done: 0, row: -1, bank: 0, wd: '0};
        end
        chk("req_ready", hif.req_ready_o, !busy && rows_left == 0);
        chk("wr_ready", hif.wr_data_ready_o, !busy && rows_left > 0);
        chk("bank_sel", bank_sel, busy ? bank_hot(c.bank) : 128'd0);
        chk("nprecharge", npre, c.npre);
        chk("w2b", w2b, c.w2b);
        chk("saen", saen, c.saen);
        chk("wl", wl, onehot(c.row));
        chk("rd_valid", hif.rd_valid_o, c.rdv);
        chk("done", hif.done_o, c.done);
        if (c.rdv) chk("rd_data", hif.rd_data_o, sa_prev);
        if (c.w2b) chk("wdata", wdata, c.wd);
        done_cnt += int'(hif.done_o);
        if (hif.rd_valid_o) rdv_cyc.push_back(cyc);
        if (wl != '0 && !prev_wl_on) begin
            wl_log.push_back(hot_index(wl));
            wd_log.push_back(wdata);
        end
        prev_wl_on = (wl != '0);
    endtask

    task automatic model_advance();
        if (exp_q.size() > 0) begin
            exp_q.delete(0);
        end else if (rows_left > 0) begin
            if (hif.wr_data_valid_i) begin
                rows_left--;
                push_row(1'b1, m_row, m_bank, rows_left == 0, hif.wr_data_i);
                m_row = (m_row + 1) % NUM_ROWS;
            end
        end else if (hif.req_valid_i) begin
            m_bank = int'(hif.req_bank_i);
            m_row  = int'(hif.req_addr_i);
            if (hif.req_write_i) rows_left = int'(hif.req_len_i) + 1;
            else begin
                for (int i = 0; i <= int'(hif.req_len_i); i++)
                    push_row(1'b0, (m_row + i) % NUM_ROWS, m_bank, i == int'(hif.req_len_i), '0);
            end
        end
    endtask

    task automatic idle_in();
        hif.req_valid_i = 0; hif.req_write_i = 0; hif.req_bank_i = '0; hif.req_addr_i = '0;
        hif.req_len_i = '0; hif.abort_i = 0; hif.wr_data_i = '0; hif.wr_data_valid_i = 0;
    endtask

    task automatic step(input bit rv, input bit wr, input int bank, input int addr,
                        input int len, input bit dv, input logic [31:0] d);
        @(negedge clk);
        sa_prev             = sa_data;
        hif.req_valid_i     = rv;
        hif.req_write_i     = wr;
        hif.req_bank_i      = BANK_W'(bank);
        hif.req_addr_i      = ROW_W'(addr);
        hif.req_len_i       = LEN_W'(len);
        hif.abort_i         = 1'b0;
        hif.wr_data_valid_i = dv;
        hif.wr_data_i       = d;
        sa_data             = $urandom();
        #1;
        model_check();
        model_advance();
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || rows_left > 0) && n < budget) begin
            step(0, 0, 0, 0, 0, 1'b1, $urandom());
            n++;
        end
        chk("drain_timeout", (exp_q.size() > 0 || rows_left > 0), 1'b0);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit rv, wr, ab; int bank, addr, len; logic [31:0] sa;
        bit ready, wrdy; int bsel; bit npre, w2b, saen; int wlrow;
        bit rdv, done; logic [31:0] rdata; bit chk_rd;
    } vec_t;

    localparam logic [31:0] A5 = 32'hA5A5A5A5;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            //rv wr ab bk ad ln sa   rdy wrd bsel np w2b sa wl  rdv dn rdata chk
            '{0, 0, 0, 0, 0, 0, A5,  1,  0,  0,   0, 0,  0, -1, 0,  0, 0,   0},  // idle after reset
            '{1, 0, 0, 1, 5, 0, A5,  1,  0,  0,   0, 0,  0, -1, 0,  0, 0,   0},  // accept read b1 r5
            '{0, 0, 0, 0, 0, 0, A5,  0,  0,  2,   1, 0,  0, -1, 0,  0, 0,   0},  // ph0
            '{0, 0, 0, 0, 0, 0, A5,  0,  0,  2,   1, 0,  0,  5, 0,  0, 0,   0},  // ph1
            '{0, 0, 0, 0, 0, 0, A5,  0,  0,  2,   1, 0,  1,  5, 0,  0, 0,   0},  // ph2 sense
            '{0, 0, 0, 0, 0, 0, A5,  0,  0,  2,   0, 0,  0, -1, 1,  1, A5,  1},  // ph3 data+done
            '{0, 0, 0, 0, 0, 0, A5,  1,  0,  0,   0, 0,  0, -1, 0,  0, 0,   0},  // ready again
            '{1, 1, 0, 0, 9, 3, A5,  1,  0,  0,   0, 0,  0, -1, 0,  0, 0,   0},  // accept write
            '{0, 0, 1, 0, 0, 0, A5,  0,  1,  0,   0, 0,  0, -1, 0,  1, 0,   0},  // abort in WR_WAIT
            '{0, 0, 0, 0, 0, 0, A5,  1,  0,  0,   0, 0,  0, -1, 0,  0, 0,   0}   // back to idle
        };

        idle_in();
        hif6.req_valid_i = 0; hif6.req_write_i = 0; hif6.req_bank_i = '0; hif6.req_addr_i = '0;
        hif6.req_len_i = '0; hif6.abort_i = 0; hif6.wr_data_i = '0; hif6.wr_data_valid_i = 0;
        sa_data = '0;
        sa6     = 32'h12345678;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", hif.req_ready_o, 1'b1);
        chk("rst_wr_ready", hif.wr_data_ready_o, 1'b0);
        chk("rst_bank_sel", bank_sel, 128'd0);
        chk("rst_array", {npre, w2b, saen}, 3'b000);
        chk("rst_wl", wl, 128'd0);
        chk("rst_rd_valid_done", {hif.rd_valid_o, hif.done_o}, 2'b00);
        chk("rst_wdata", wdata, 128'd0);
        chk("rst_rd_data", hif.rd_data_o, 128'd0);
        chk("rst6_ready", hif6.req_ready_o, 1'b1);
        chk("rst6_wdata", wdata6, 128'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Table: single read of bank 1 row 5, then abort while waiting for write data
        for (int i = 0; i < $size(vecs); i++) begin
            @(negedge clk);
            hif.req_valid_i = vecs[i].rv;
            hif.req_write_i = vecs[i].wr;
            hif.req_bank_i  = BANK_W'(vecs[i].bank);
            hif.req_addr_i  = ROW_W'(vecs[i].addr);
            hif.req_len_i   = LEN_W'(vecs[i].len);
            hif.abort_i     = vecs[i].ab;
            hif.wr_data_valid_i = 1'b0;
            sa_data         = vecs[i].sa;
            #1;
            chk($sformatf("tv%0d_req_ready", i), hif.req_ready_o, vecs[i].ready);
            chk($sformatf("tv%0d_wr_ready", i), hif.wr_data_ready_o, vecs[i].wrdy);
            chk($sformatf("tv%0d_bank_sel", i), bank_sel, vecs[i].bsel);
            chk($sformatf("tv%0d_npre", i), npre, vecs[i].npre);
            chk($sformatf("tv%0d_w2b", i), w2b, vecs[i].w2b);
            chk($sformatf("tv%0d_saen", i), saen, vecs[i].saen);
            chk($sformatf("tv%0d_wl", i), wl, onehot(vecs[i].wlrow));
            chk($sformatf("tv%0d_rd_valid", i), hif.rd_valid_o, vecs[i].rdv);
            chk($sformatf("tv%0d_done", i), hif.done_o, vecs[i].done);
            if (vecs[i].chk_rd) chk($sformatf("tv%0d_rd_data", i), hif.rd_data_o, vecs[i].rdata);
        end
        idle_in();

        // Write burst from row 127, len 2, 2-cycle gap before each beat
        wl_log.delete(); wd_log.delete(); done_cnt = 0;
        step(1, 1, 0, 127, 2, 0, '0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 0, 0, '0);
            step(0, 0, 0, 0, 0, 0, '0);
            step(0, 0, 0, 0, 0, 1, 32'hDEAD0000 + 32'(k));
            repeat (PHASES) step(0, 0, 0, 0, 0, 0, '0);
        end
        step(0, 0, 0, 0, 0, 0, '0);
        chk("wr_row_count", wl_log.size(), 3);
        chk("wr_row0", qget(wl_log, 0), 127);
        chk("wr_row1", qget(wl_log, 1), 0);
        chk("wr_row2", qget(wl_log, 2), 1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("wr_data%0d", i), (i < wd_log.size()) ? wd_log[i] : 32'hX, 32'hDEAD0001 + 32'(i));
        chk("wr_done_count", done_cnt, 1);

        // Read burst len 3 from row 10
        rdv_cyc.delete(); wl_log.delete(); done_cnt = 0;
        step(1, 0, 0, 10, 3, 0, '0);
        repeat (4 * PHASES + 1) step(0, 0, 0, 0, 0, 0, '0);
        chk("rd_pulse_count", rdv_cyc.size(), 4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("rd_spacing%0d", i), qget(rdv_cyc, i) - qget(rdv_cyc, i - 1), PHASES);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rd_wl_row%0d", i), qget(wl_log, i), 10 + i);
        chk("rd_done_count", done_cnt, 1);

        // Abort at ph1 of beat 0 of a len-7 read
        begin
            int  dn = 0;
            bit  saw21 = 0;
            @(negedge clk);
            hif.req_valid_i = 1; hif.req_write_i = 0; hif.req_bank_i = '0;
            hif.req_addr_i = ROW_W'(20); hif.req_len_i = LEN_W'(7);
            #1;
            chk("ab_accept_ready", hif.req_ready_o, 1'b1);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                hif.req_valid_i = 0;
                hif.abort_i     = (k == 1);
                #1;
                if (k == 1) chk("ab_wl_row20", wl, onehot(20));
                if (k == 3) chk("ab_done_rdv", {hif.done_o, hif.rd_valid_o}, 2'b11);
                if (k == 4) chk("ab_idle_ready", hif.req_ready_o, 1'b1);
                if (wl[21]) saw21 = 1;
                dn += int'(hif.done_o);
            end
            chk("ab_no_row21", saw21, 1'b0);
            chk("ab_done_count", dn, 1);
            idle_in();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? 126 + $urandom_range(0, 1) : $urandom_range(0, 127),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom());
        end
        drain(300);
        step(0, 0, 0, 0, 0, 0, '0);

        // Asynchronous reset in the middle of a write row
        step(1, 1, 1, 3, 0, 0, '0);
        step(0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        step(0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, '0);
        @(negedge clk);
        idle_in();
        #1;
        chk("mr_wl_before", wl, onehot(3));
        #1;
        nrst = 1'b0;
        #1;
        chk("mr_wl", wl, 128'd0);
        chk("mr_w2b_npre", {w2b, npre}, 2'b00);
        chk("mr_bank_sel", bank_sel, 128'd0);
        chk("mr_ready_in_reset", hif.req_ready_o, 1'b1);
        exp_q.delete();
        rows_left = 0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_ready_after", hif.req_ready_o, 1'b1);
        chk("mr_wl_after", wl, 128'd0);

        // PHASES=6 instance, single read of row 40
        @(negedge clk);
        hif6.req_valid_i = 1; hif6.req_write_i = 0; hif6.req_bank_i = '0;
        hif6.req_addr_i = ROW_W'(40); hif6.req_len_i = '0;
        #1;
        chk("p6_accept_ready", hif6.req_ready_o, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            hif6.req_valid_i = 0;
            #1;
            chk($sformatf("p6_wl_ph%0d", k), wl6, (k >= 1 && k <= 4) ? onehot(40) : 128'd0);
            chk($sformatf("p6_saen_ph%0d", k), saen6, k == 4);
            chk($sformatf("p6_rdv_done_ph%0d", k), {hif6.rd_valid_o, hif6.done_o}, (k == 5) ? 2'b11 : 2'b00);
            chk($sformatf("p6_bank_ph%0d", k), bank_sel6, (k < 6) ? 128'd1 : 128'd0);
            chk($sformatf("p6_npre_w2b_ph%0d", k), {npre6, w2b6}, (k < 5) ? 2'b10 : 2'b00);
            if (k == 5) chk("p6_rd_data", hif6.rd_data_o, 32'h12345678);
            if (k == 6) chk("p6_ready", hif6.req_ready_o, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
